trans_sched_ipa: RTL and testbench

Command scheduler in front of the channel's transfer-ID allocator and command queue.
- Arbitrates command requests from NB_CORES cores using round-robin.
- Obtains a free SID from the allocator and issues the command downstream with its SID, CID and termination-enable bits.
- Keeps an SID-to-owner table and per-core outstanding counters.
- Throttles any core that reaches MAX_OUTST transfers in flight.

---
 rtl/trans_sched_ipa_pkg.sv | 28 ++
 rtl/trans_sched_rr_arb_ipa.sv | 44 ++++
 rtl/trans_sched_ipa.sv | 174 +++++++++++++++++
 tb/tb_trans_sched_ipa.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trans_sched_ipa_pkg.sv
// Shared types and default widths for the transfer command scheduler.
package trans_sched_ipa_pkg;

  localparam int DEF_NB_CORES     = 4;
  localparam int DEF_NB_TRANSFERS = 8;
  localparam int DEF_SID_W        = $clog2(DEF_NB_TRANSFERS);
  localparam int DEF_CID_W        = $clog2(DEF_NB_CORES);
  localparam int DEF_MAX_OUTST    = 4;
  localparam int DEF_CNT_W        = $clog2(DEF_MAX_OUTST + 1);

  typedef enum logic [1:0] {
    IDLE,
    ALLOC,
    ISSUE
  } state_t;

  typedef struct packed {
    logic [DEF_CID_W-1:0] cid;
    logic                 ele;
    logic                 ile;
    logic                 ble;
  } cmd_attr_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/trans_sched_rr_arb_ipa.sv
// Combinational round-robin picker with an optional high-priority class;
// both classes scan from the same pointer.
module trans_sched_rr_arb_ipa
  import trans_sched_ipa_pkg::*;
#(
  parameter int NB_CORES = DEF_NB_CORES,
  parameter int CID_W    = DEF_CID_W
) (
  input  logic [NB_CORES-1:0] elig,
  input  logic [NB_CORES-1:0] prio,
  input  logic [CID_W-1:0]    ptr,
  output logic [CID_W-1:0]    winner,
  output logic                valid
);

  logic             hi_found;
  logic             lo_found;
  logic [CID_W-1:0] hi_idx;
  logic [CID_W-1:0] lo_idx;
  int               idx;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    idx      = 0;
    for (int i = 0; i < NB_CORES; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NB_CORES) idx = idx - NB_CORES;
      if (elig[idx] && prio[idx] && !hi_found) begin
        hi_found = 1'b1;
        hi_idx   = CID_W'(idx);
      end
      if (elig[idx] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = CID_W'(idx);
      end
    end
    winner = hi_found ? hi_idx : lo_idx;
    valid  = lo_found;
  end

endmodule

// File: rtl/trans_sched_ipa.sv
// Round-robin command scheduler: picks a core, fetches a SID, issues the command
// and tracks per-core in-flight counts. Define TRANS_SCHED_PRIO_EN for core_prio_i.
module trans_sched_ipa
  import trans_sched_ipa_pkg::*;
#(
  parameter int NB_CORES        = DEF_NB_CORES,
  parameter int NB_TRANSFERS    = DEF_NB_TRANSFERS,
  parameter int TRANS_SID_WIDTH = DEF_SID_W,
  parameter int TRANS_CID_WIDTH = DEF_CID_W,
  parameter int MAX_OUTST       = DEF_MAX_OUTST,
  parameter int CNT_WIDTH       = DEF_CNT_W
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [NB_CORES-1:0]                       core_req_i,
  input  logic [NB_CORES-1:0]                       core_ele_i,
  input  logic [NB_CORES-1:0]                       core_ile_i,
  input  logic [NB_CORES-1:0]                       core_ble_i,
`ifdef TRANS_SCHED_PRIO_EN
  input  logic [NB_CORES-1:0]                       core_prio_i,
`endif
  output logic [NB_CORES-1:0]                       core_gnt_o,
  output logic [NB_CORES-1:0][TRANS_SID_WIDTH-1:0]  core_sid_o,
  output logic                                      alloc_req_o,
  input  logic                                      alloc_gnt_i,
  input  logic [TRANS_SID_WIDTH-1:0]                alloc_sid_i,
  output logic                                      cmd_req_o,
  input  logic                                      cmd_gnt_i,
  output logic [TRANS_SID_WIDTH-1:0]                cmd_sid_o,
  output logic [TRANS_CID_WIDTH-1:0]                cmd_cid_o,
  output logic                                      cmd_ele_o,
  output logic                                      cmd_ile_o,
  output logic                                      cmd_ble_o,
  input  logic [NB_TRANSFERS-1:0]                   term_sig_i,
  output logic [NB_CORES-1:0][CNT_WIDTH-1:0]        outst_cnt_o,
  output logic                                      busy_o
);

  localparam int DEC_W = $clog2(NB_TRANSFERS + 1);
  localparam int RAW_W = CNT_WIDTH + DEC_W + 2;

  state_t                                    state, state_nxt;
  logic [TRANS_CID_WIDTH-1:0]                rr_ptr;
  cmd_attr_t                                 attr_p0;
  logic [TRANS_SID_WIDTH-1:0]                sid_p1;
  logic [NB_TRANSFERS-1:0]                   owner_vld;
  logic [NB_TRANSFERS-1:0][TRANS_CID_WIDTH-1:0] owner_cid;
  logic [NB_CORES-1:0][CNT_WIDTH-1:0]        cnt;
  logic [NB_CORES-1:0]                       elig;
  logic [NB_CORES-1:0]                       prio;
  logic [TRANS_CID_WIDTH-1:0]                arb_winner;
  logic                                      arb_valid;
  logic                                      issue_fire;
  logic [NB_TRANSFERS-1:0]                   set_mask;
  logic [NB_TRANSFERS-1:0]                   term_hit;
  logic [NB_CORES-1:0][DEC_W-1:0]            dec;
  logic signed [RAW_W-1:0]                   cnt_raw [NB_CORES];
  logic [NB_CORES-1:0]                       cnt_err;

  function automatic logic [CNT_WIDTH-1:0] sat_cnt(input logic signed [RAW_W-1:0] raw);
    if (raw < 0) return '0;
    if (raw > RAW_W'(MAX_OUTST)) return CNT_WIDTH'(MAX_OUTST);
    return CNT_WIDTH'(raw);
  endfunction

`ifdef TRANS_SCHED_PRIO_EN
  assign prio = core_prio_i;
`else
  assign prio = '0;
`endif

  always_comb begin
    for (int c = 0; c < NB_CORES; c++)
      elig[c] = core_req_i[c] && (cnt[c] < CNT_WIDTH'(MAX_OUTST));
  end

  trans_sched_rr_arb_ipa #(
    .NB_CORES (NB_CORES),
    .CID_W    (TRANS_CID_WIDTH)
  ) u_arb (
    .elig   (elig),
    .prio   (prio),
    .ptr    (rr_ptr),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  always_comb begin
    state_nxt   = state;
    alloc_req_o = 1'b0;
    cmd_req_o   = 1'b0;
    issue_fire  = 1'b0;
    case (state)
      IDLE:  if (arb_valid) state_nxt = ALLOC;
      ALLOC: begin
        alloc_req_o = 1'b1;
        if (alloc_gnt_i) state_nxt = ISSUE;
      end
      ISSUE: begin
        cmd_req_o = 1'b1;
        if (cmd_gnt_i) begin
          issue_fire = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A SID being written this cycle ignores its own term pulse (the write wins).
  always_comb begin
    for (int s = 0; s < NB_TRANSFERS; s++) begin
      set_mask[s] = issue_fire && (sid_p1 == TRANS_SID_WIDTH'(s));
      term_hit[s] = term_sig_i[s] && owner_vld[s] && !set_mask[s];
    end
    for (int c = 0; c < NB_CORES; c++) dec[c] = '0;
    for (int s = 0; s < NB_TRANSFERS; s++)
      if (term_hit[s]) dec[owner_cid[s]] = dec[owner_cid[s]] + DEC_W'(1);
    for (int c = 0; c < NB_CORES; c++) begin
      cnt_raw[c] = RAW_W'(cnt[c])
                 + RAW_W'(issue_fire && (attr_p0.cid == TRANS_CID_WIDTH'(c)))
                 - RAW_W'(dec[c]);
      cnt_err[c] = (cnt_raw[c] < 0) || (cnt_raw[c] > RAW_W'(MAX_OUTST));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner_vld <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      owner_vld <= (owner_vld & ~term_hit) | set_mask;
      if (issue_fire)
        rr_ptr <= TRANS_CID_WIDTH'(wrap_inc(int'(attr_p0.cid), NB_CORES));
      for (int c = 0; c < NB_CORES; c++) cnt[c] <= sat_cnt(cnt_raw[c]);
    end
  end

  // Stage 0: winner attributes latched in IDLE; stage 1: SID latched in ALLOC.
  always_ff @(posedge clk_i) begin
    if (state == IDLE && arb_valid)
      attr_p0 <= '{cid: arb_winner, ele: core_ele_i[arb_winner],
                   ile: core_ile_i[arb_winner], ble: core_ble_i[arb_winner]};
    if (alloc_req_o && alloc_gnt_i) sid_p1 <= alloc_sid_i;
    if (issue_fire) owner_cid[sid_p1] <= attr_p0.cid;
  end

  assign cmd_sid_o = cmd_req_o ? sid_p1 : '0;
  assign cmd_cid_o = cmd_req_o ? attr_p0.cid : '0;
  assign cmd_ele_o = cmd_req_o && attr_p0.ele;
  assign cmd_ile_o = cmd_req_o && attr_p0.ile;
  assign cmd_ble_o = cmd_req_o && attr_p0.ble;

  always_comb begin
    for (int c = 0; c < NB_CORES; c++) begin
      core_gnt_o[c] = issue_fire && (attr_p0.cid == TRANS_CID_WIDTH'(c));
      core_sid_o[c] = core_gnt_o[c] ? sid_p1 : '0;
    end
  end

  assign outst_cnt_o = cnt;
  assign busy_o      = (state != IDLE) || (|cnt);

  a_cnt_range: assert property (@(posedge clk_i) disable iff (rst_i) cnt_err == '0);

  for (genvar c = 0; c < NB_CORES; c++) begin : g_hold
    a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      (core_req_i[c] && !core_gnt_o[c]) |=> core_req_i[c]);
  end

endmodule

// File: tb/tb_trans_sched_ipa.sv
// Directed self-checking bench for trans_sched_ipa; the priority case runs only
// when TRANS_SCHED_PRIO_EN is defined.
module tb_trans_sched_ipa;

  logic             clk = 1'b0;
  logic             rst_i;
  logic [3:0]       core_req_i, core_ele_i, core_ile_i, core_ble_i;
`ifdef TRANS_SCHED_PRIO_EN
  logic [3:0]       core_prio_i;
`endif
  logic [3:0]       core_gnt_o;
  logic [3:0][2:0]  core_sid_o;
  logic             alloc_req_o, alloc_gnt_i;
  logic [2:0]       alloc_sid_i;
  logic             cmd_req_o, cmd_gnt_i;
  logic [2:0]       cmd_sid_o;
  logic [1:0]       cmd_cid_o;
  logic             cmd_ele_o, cmd_ile_o, cmd_ble_o;
  logic [7:0]       term_sig_i;
  logic [3:0][2:0]  outst_cnt_o;
  logic             busy_o;

  logic             alloc_auto, cmd_auto;
  logic [2:0]       sid_base;
  logic [2:0]       alloc_idx;
  int               n_cmp = 0;
  int               n_err = 0;
  int               n_issued;
  int               quota [4];
  int               exp_order [$];

  always #5 clk = ~clk;

  assign alloc_gnt_i = alloc_auto & alloc_req_o;
  assign cmd_gnt_i   = cmd_auto & cmd_req_o;
  assign alloc_sid_i = sid_base + alloc_idx;

  always @(posedge clk) begin
    if (rst_i) alloc_idx <= '0;
    else if (alloc_gnt_i) alloc_idx <= alloc_idx + 3'd1;
  end

  trans_sched_ipa dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .core_req_i  (core_req_i),
    .core_ele_i  (core_ele_i),
    .core_ile_i  (core_ile_i),
    .core_ble_i  (core_ble_i),
`ifdef TRANS_SCHED_PRIO_EN
    .core_prio_i (core_prio_i),
`endif
    .core_gnt_o  (core_gnt_o),
    .core_sid_o  (core_sid_o),
    .alloc_req_o (alloc_req_o),
    .alloc_gnt_i (alloc_gnt_i),
    .alloc_sid_i (alloc_sid_i),
    .cmd_req_o   (cmd_req_o),
    .cmd_gnt_i   (cmd_gnt_i),
    .cmd_sid_o   (cmd_sid_o),
    .cmd_cid_o   (cmd_cid_o),
    .cmd_ele_o   (cmd_ele_o),
    .cmd_ile_o   (cmd_ile_o),
    .cmd_ble_o   (cmd_ble_o),
    .term_sig_i  (term_sig_i),
    .outst_cnt_o (outst_cnt_o),
    .busy_o      (busy_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i      = 1'b1;
    core_req_i = '0;
    core_ele_i = '0;
    core_ile_i = '0;
    core_ble_i = '0;
`ifdef TRANS_SCHED_PRIO_EN
    core_prio_i = '0;
`endif
    term_sig_i = '0;
    alloc_auto = 1'b1;
    cmd_auto   = 1'b1;
    sid_base   = '0;
    n_issued   = 0;
    repeat (2) next_cyc();
    rst_i = 1'b0;
  endtask

  // Runs requests until exp_order is granted, dropping each core once its quota is used.
  task automatic serve(input int budget);
    int         pos;
    logic [3:0] drop;
    pos  = 0;
    drop = '0;
    for (int cyc = 0; cyc < budget && pos < exp_order.size(); cyc++) begin
      next_cyc();
      core_req_i = core_req_i & ~drop;
      drop = '0;
      @(negedge clk);
      if (core_gnt_o != '0) begin
        int c;
        c = exp_order[pos];
        check_eq("gnt_order", core_gnt_o, 32'(4'b0001 << c));
        check_eq("gnt_sid", core_sid_o[c], 32'(sid_base + 3'(n_issued)));
        check_eq("cmd_cid", cmd_cid_o, c);
        check_eq("cmd_ile", cmd_ile_o, core_ile_i[c]);
        n_issued++;
        pos++;
        for (int i = 0; i < 4; i++)
          if (core_gnt_o[i]) begin
            quota[i]--;
            if (quota[i] == 0) drop[i] = 1'b1;
          end
      end
    end
    check_eq("serve_done", pos, exp_order.size());
    next_cyc();
    core_req_i = core_req_i & ~drop;
  endtask

  task automatic wait_cmd_req(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_req_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("cmd_req_wait", cmd_req_o, 1);
  endtask

  initial begin
    // Single command: core1, allocator answers one cycle late, immediate accept.
    do_reset();
    alloc_auto = 1'b0;
    sid_base   = 3'd5;
    core_req_i = 4'b0010;
    core_ele_i = 4'b0010;
    @(negedge clk);
    check_eq("rst_gnt", core_gnt_o, 0);
    check_eq("rst_alloc_req", alloc_req_o, 0);
    check_eq("rst_cmd_req", cmd_req_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_cnt", outst_cnt_o, 0);
    next_cyc();
    @(negedge clk);
    check_eq("t1_alloc_req_c1", alloc_req_o, 1);
    check_eq("t1_gnt_c1", core_gnt_o, 0);
    next_cyc();
    alloc_auto = 1'b1;
    @(negedge clk);
    check_eq("t1_alloc_req_c2", alloc_req_o, 1);
    check_eq("t1_cmd_req_c2", cmd_req_o, 0);
    next_cyc();
    @(negedge clk);
    check_eq("t1_gnt_c3", core_gnt_o, 4'b0010);
    check_eq("t1_core_sid", core_sid_o[1], 5);
    check_eq("t1_cmd_sid", cmd_sid_o, 5);
    check_eq("t1_cmd_cid", cmd_cid_o, 1);
    check_eq("t1_cmd_ele", cmd_ele_o, 1);
    check_eq("t1_cmd_ile", cmd_ile_o, 0);
    next_cyc();
    core_req_i = '0;
    @(negedge clk);
    check_eq("t1_cnt1", outst_cnt_o[1], 1);
    check_eq("t1_gnt_after", core_gnt_o, 0);
    check_eq("t1_busy", busy_o, 1);

    // Round-robin: all four cores request, order 0,1,2,3,0.
    do_reset();
    core_req_i = 4'b1111;
    core_ile_i = 4'b1010;
    quota = '{2, 1, 1, 1};
    exp_order = '{0, 1, 2, 3, 0};
    serve(40);
    @(negedge clk);
    check_eq("rr_cnt0", outst_cnt_o[0], 2);
    check_eq("rr_cnt1", outst_cnt_o[1], 1);
    check_eq("rr_cnt2", outst_cnt_o[2], 1);
    check_eq("rr_cnt3", outst_cnt_o[3], 1);

    // Throttle: core0 reaches 4 in flight (SIDs 0..3), then is skipped for core2.
    do_reset();
    core_req_i = 4'b0001;
    quota = '{4, 0, 0, 0};
    exp_order = '{0, 0, 0, 0};
    serve(40);
    core_req_i = 4'b0101;
    quota = '{99, 0, 1, 0};
    exp_order = '{2};
    serve(20);
    @(negedge clk);
    check_eq("max_cnt0", outst_cnt_o[0], 4);
    check_eq("max_cnt2", outst_cnt_o[2], 1);
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      @(negedge clk);
      check_eq("max_skip", alloc_req_o, 0);
    end
    next_cyc();
    term_sig_i = 8'b0000_0010;
    next_cyc();
    term_sig_i = '0;
    @(negedge clk);
    check_eq("max_cnt0_term", outst_cnt_o[0], 3);
    quota = '{1, 0, 0, 0};
    exp_order = '{0};
    serve(20);
    @(negedge clk);
    check_eq("max_cnt0_refill", outst_cnt_o[0], 4);
    next_cyc();
    term_sig_i = 8'b1000_0000;
    next_cyc();
    term_sig_i = '0;
    @(negedge clk);
    check_eq("invalid_term_cnt0", outst_cnt_o[0], 4);
    check_eq("invalid_term_cnt2", outst_cnt_o[2], 1);
    next_cyc();
    term_sig_i = 8'b0000_0101;
    next_cyc();
    term_sig_i = '0;
    @(negedge clk);
    check_eq("multi_term_cnt0", outst_cnt_o[0], 2);

    // Same-cycle term and issue for core2: old SID 0 ends, new SID 1 written.
    do_reset();
    core_req_i = 4'b0100;
    quota = '{0, 0, 1, 0};
    exp_order = '{2};
    serve(20);
    cmd_auto   = 1'b0;
    core_req_i = 4'b0100;
    wait_cmd_req(10);
    next_cyc();
    term_sig_i = 8'b0000_0011;
    cmd_auto   = 1'b1;
    @(negedge clk);
    check_eq("coll_gnt", core_gnt_o, 4'b0100);
    check_eq("coll_sid", core_sid_o[2], 1);
    next_cyc();
    term_sig_i = '0;
    core_req_i = '0;
    @(negedge clk);
    check_eq("coll_cnt2", outst_cnt_o[2], 1);
    next_cyc();
    term_sig_i = 8'b0000_0010;
    next_cyc();
    term_sig_i = '0;
    @(negedge clk);
    check_eq("coll_new_owner", outst_cnt_o[2], 0);
    next_cyc();
    term_sig_i = 8'b0000_0001;
    next_cyc();
    term_sig_i = '0;
    @(negedge clk);
    check_eq("coll_stale_term", outst_cnt_o[2], 0);
    check_eq("coll_busy", busy_o, 0);

    // Stalled downstream: fields stay stable, then reset abandons the command.
    do_reset();
    cmd_auto   = 1'b0;
    sid_base   = 3'd6;
    core_req_i = 4'b1000;
    core_ile_i = 4'b1000;
    core_ble_i = 4'b1000;
    wait_cmd_req(10);
    for (int i = 0; i < 10; i++) begin
      next_cyc();
      @(negedge clk);
      check_eq("stall_fields",
               {cmd_req_o, cmd_sid_o, cmd_cid_o, cmd_ele_o, cmd_ile_o, cmd_ble_o},
               {1'b1, 3'd6, 2'd3, 1'b0, 1'b1, 1'b1});
    end
    next_cyc();
    rst_i = 1'b1;
    next_cyc();
    core_req_i = '0;
    @(negedge clk);
    check_eq("midrst_outs",
             {core_gnt_o, core_sid_o, alloc_req_o, cmd_req_o, cmd_sid_o, cmd_cid_o,
              cmd_ele_o, cmd_ile_o, cmd_ble_o, outst_cnt_o, busy_o}, 0);
    next_cyc();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("midrst_no_gnt", {core_gnt_o, cmd_req_o, busy_o}, 0);
      next_cyc();
    end

`ifdef TRANS_SCHED_PRIO_EN
    // Priority class wins over the pointer order.
    do_reset();
    core_prio_i = 4'b1000;
    core_req_i  = 4'b1001;
    quota = '{1, 0, 0, 1};
    exp_order = '{3, 0};
    serve(30);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
